// File: rtl/decoder_pkg.sv
// Shared types and width helpers for the stream downsizing FIFO.
// Covers the unpacker state encoding, the lane-index width and the level width.
package decoder_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StUnpack
   } unpack_state_e;

   function automatic int unsigned lane_idx_width(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Beat storage for the downsizing FIFO: write/read pointers with a wrap bit,
// a beat-level counter, and registered full/almost-full flags.
module stream_fifo_mem
   import decoder_pkg::*;
#(
   parameter int unsigned Width    = 84,
   parameter int unsigned Depth    = 128,
   parameter int unsigned AfThresh = Depth - 4
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            wr_en_i,
   input  logic [Width-1:0]                wr_data_i,
   input  logic                            rd_en_i,
   output logic [Width-1:0]                rd_data_o,
   output logic                            empty_o,
   output logic                            not_full_o,
   output logic                            almost_full_o,
   output logic [level_width(Depth)-1:0]   level_o
);

   localparam int unsigned AW  = $clog2(Depth);
   localparam int unsigned LVW = level_width(Depth);
   localparam logic [LVW-1:0] DepthL = LVW'(Depth);
   localparam logic [LVW-1:0] AfL    = LVW'(AfThresh);

   logic [Width-1:0] mem_q [Depth];
   logic [AW:0]      wptr_q, rptr_q;
   logic [LVW-1:0]   level_q, level_d;
   logic             not_full_q, almost_full_q;

   always_comb begin
      level_d = level_q;
      if (wr_en_i && !rd_en_i) begin
         level_d = level_q + LVW'(1);
      end else if (!wr_en_i && rd_en_i) begin
         level_d = level_q - LVW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q        <= '0;
         rptr_q        <= '0;
         level_q       <= '0;
         not_full_q    <= 1'b0;
         almost_full_q <= 1'b0;
      end else begin
         if (wr_en_i) wptr_q <= wptr_q + (AW+1)'(1);
         if (rd_en_i) rptr_q <= rptr_q + (AW+1)'(1);
         level_q       <= level_d;
         // Flags track the next level so they never lag the counter.
         not_full_q    <= (level_d < DepthL);
         almost_full_q <= (level_d >= AfL);
      end
   end

   assign rd_data_o     = mem_q[rptr_q[AW-1:0]];
   assign empty_o       = (wptr_q == rptr_q);
   assign not_full_o    = not_full_q;
   assign almost_full_o = almost_full_q;
   assign level_o       = level_q;

endmodule

// File: rtl/stream_downsize_fifo.sv
// Buffers wide multi-lane beats and emits their kept lanes one sample per
// transfer, carrying start/end-of-frame markers onto the first/last emitted lane.
module stream_downsize_fifo
   import decoder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LANES      = 5,
   parameter int unsigned DEPTH      = 128,
   parameter int unsigned AF_THRESH  = DEPTH - 4
) (
   input  logic                          ACLK,
   input  logic                          ARESET_N,
   input  logic                          EN,
   input  logic [LANES*DATA_WIDTH-1:0]   S_TDATA,
   input  logic [LANES-1:0]              S_TKEEP,
   input  logic                          S_TVALID,
   output logic                          S_TREADY,
   input  logic                          S_TUSER,
   input  logic                          S_TLAST,
   output logic [DATA_WIDTH-1:0]         M_TDATA,
   output logic                          M_TVALID,
   input  logic                          M_TREADY,
   output logic                          M_TUSER,
   output logic                          M_TLAST,
   output logic [level_width(DEPTH)-1:0] LEVEL,
   output logic                          ALMOST_FULL,
   output logic                          KEEP_ERR
);

   localparam int unsigned LW     = lane_idx_width(LANES);
   localparam int unsigned DW_ALL = LANES * DATA_WIDTH;
   localparam int unsigned BW     = DW_ALL + LANES + 2;

   logic             accept, keep_zero, keep_bad, wr_en, rd_en;
   logic             fifo_empty, not_full;
   logic [LANES-1:0] keep_inc;
   logic [BW-1:0]    rd_data;

   assign S_TREADY  = EN && not_full;
   assign accept    = S_TVALID && S_TREADY;
   assign keep_zero = (S_TKEEP == '0);
   assign keep_inc  = S_TKEEP + LANES'(1);
   // Last beats may be a contiguous prefix; every other beat must be fully kept.
   assign keep_bad  = keep_zero ||
                      (S_TLAST ? ((S_TKEEP & keep_inc) != '0) : (S_TKEEP != '1));
   assign wr_en     = accept && !keep_zero;

   stream_fifo_mem #(
      .Width   (BW),
      .Depth   (DEPTH),
      .AfThresh(AF_THRESH)
   ) u_mem (
      .clk_i        (ACLK),
      .rst_ni       (ARESET_N),
      .wr_en_i      (wr_en),
      .wr_data_i    ({S_TLAST, S_TUSER, S_TKEEP, S_TDATA}),
      .rd_en_i      (rd_en),
      .rd_data_o    (rd_data),
      .empty_o      (fifo_empty),
      .not_full_o   (not_full),
      .almost_full_o(ALMOST_FULL),
      .level_o      (LEVEL)
   );

   unpack_state_e       state_q;
   logic [BW-1:0]       beat_q;
   logic [LW-1:0]       lane_q, next_lane, first_lane;
   logic                first_q, has_next, out_free, emit, load;
   logic                m_tvalid_q, m_tuser_q, m_tlast_q, keep_err_q;
   logic [DATA_WIDTH-1:0] m_tdata_q;
   logic [DW_ALL-1:0]   beat_data;
   logic [LANES-1:0]    beat_keep, rd_keep;
   logic                beat_user, beat_last;

   assign {beat_last, beat_user, beat_keep, beat_data} = beat_q;
   assign rd_keep = rd_data[DW_ALL +: LANES];

   // Descending scan so the lowest qualifying lane wins.
   always_comb begin
      has_next   = 1'b0;
      next_lane  = '0;
      first_lane = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (beat_keep[i] && (LW'(i) > lane_q)) begin
            has_next  = 1'b1;
            next_lane = LW'(i);
         end
         if (rd_keep[i]) first_lane = LW'(i);
      end
   end

   assign out_free = !m_tvalid_q || M_TREADY;
   assign emit     = EN && (state_q == StUnpack) && out_free;
   assign load     = EN && !fifo_empty && ((state_q == StIdle) || (emit && !has_next));
   assign rd_en    = load;

   always_ff @(posedge ACLK or negedge ARESET_N) begin
      if (!ARESET_N) begin
         state_q    <= StIdle;
         beat_q     <= '0;
         lane_q     <= '0;
         first_q    <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tuser_q  <= 1'b0;
         m_tlast_q  <= 1'b0;
         keep_err_q <= 1'b0;
      end else begin
         if (accept && keep_bad) keep_err_q <= 1'b1;
         if (emit) begin
            m_tdata_q  <= beat_data[lane_q*DATA_WIDTH +: DATA_WIDTH];
            m_tuser_q  <= beat_user && first_q;
            m_tlast_q  <= beat_last && !has_next;
            m_tvalid_q <= 1'b1;
            lane_q     <= next_lane;
            first_q    <= 1'b0;
         end else if (M_TREADY) begin
            m_tvalid_q <= 1'b0;
         end
         // Loading overrides the lane advance so the next beat follows with no bubble.
         if (load) begin
            beat_q  <= rd_data;
            lane_q  <= first_lane;
            first_q <= 1'b1;
            state_q <= StUnpack;
         end else if (emit && !has_next) begin
            state_q <= StIdle;
         end
      end
   end

   assign M_TDATA  = m_tdata_q;
   assign M_TVALID = m_tvalid_q;
   assign M_TUSER  = m_tuser_q;
   assign M_TLAST  = m_tlast_q;
   assign KEEP_ERR = keep_err_q;

endmodule

// File: doc/stream_downsize_fifo.md
STREAM_DOWNSIZE_FIFO -- requirements
Module: stream_downsize_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, output sample width in bits.
REQ-002 SHALL have parameter LANES, default 5, samples per input beat (input width = LANES*DATA_WIDTH).
REQ-003 SHALL have parameter DEPTH, default 128, input beats buffered; power of two, >=4.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-4, almost-full level in beats.
REQ-005 SHALL have ports: ACLK  in  1  clock; ARESET_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: EN  in  1  global enable.
REQ-007 SHALL have ports: S_TDATA  in  LANES*DATA_WIDTH  input beat, lane 0 in LSBs; S_TKEEP  in  LANES  lane-valid mask.
REQ-008 SHALL have ports: S_TVALID in 1; S_TREADY out 1; S_TUSER in 1 start-of-frame; S_TLAST in 1 end-of-frame.
REQ-009 SHALL have ports: M_TDATA  out  DATA_WIDTH  sample; M_TVALID out 1; M_TREADY in 1; M_TUSER out 1; M_TLAST out 1.
REQ-010 SHALL have ports: LEVEL  out  clog2(DEPTH)+1  stored beats; ALMOST_FULL  out  1  LEVEL>=AF_THRESH; KEEP_ERR  out  1  sticky protocol error.

Function
REQ-011 SHALL accept an input beat when S_TVALID && S_TREADY at rising ACLK; S_TREADY = EN && (LEVEL<DEPTH).
REQ-012 SHALL store per beat: S_TDATA, S_TKEEP, S_TUSER, S_TLAST.
REQ-013 SHALL emit kept lanes of each beat in ascending lane order, one per M_TVALID&&M_TREADY transfer; lanes with TKEEP=0 skipped.
REQ-014 SHALL treat an all-zero S_TKEEP beat as error: beat dropped, KEEP_ERR set until reset.
REQ-015 SHALL require TKEEP contiguous from lane 0 only on TLAST beats; non-contiguous or partial non-last beat SHALL set KEEP_ERR but still emit kept lanes.
REQ-016 SHALL assert M_TUSER only with the first emitted lane of a beat stored with TUSER=1.
REQ-017 SHALL assert M_TLAST only with the last emitted lane of a beat stored with TLAST=1.
REQ-018 SHALL have registered outputs; latency from accept into empty block to M_TVALID=1 is 2 cycles.
REQ-019 SHALL sustain one sample per cycle with M_TREADY=1; next beat loaded into the unpacker in the cycle its last lane transfers (no bubble).
REQ-020 SHALL hold M_TDATA/M_TUSER/M_TLAST stable while M_TVALID && !M_TREADY.
REQ-021 SHALL, with EN=0: S_TREADY=0; a presented sample stays valid until transferred; no new lane presented afterwards until EN=1.
REQ-022 SHALL handle simultaneous write and read at LEVEL=DEPTH: S_TREADY stays 0 that cycle (no write-through on full).
REQ-023 SHALL update LEVEL on beat accept (+1) and on beat dequeue into unpacker (-1); both same cycle -> unchanged.
REQ-024 SHALL wrap read/write pointers modulo DEPTH with an extra wrap bit for full/empty.
REQ-025 SHALL unpacker states: IDLE (no beat), UNPACK (lane index 0..LANES-1); IDLE->UNPACK on non-empty FIFO; UNPACK->IDLE after last kept lane transferred with FIFO empty.

Reset
REQ-026 SHALL on ARESET_N=0 clear immediately: S_TREADY=0, M_TVALID=0, M_TDATA=0, M_TUSER=0, M_TLAST=0, LEVEL=0, ALMOST_FULL=0, KEEP_ERR=0, pointers=0, state IDLE.
REQ-027 SHALL discard all buffered beats on reset mid-frame; S_TREADY=1 first rising edge after deassertion (EN=1).

Structure
REQ-028 SHALL place lane-index and level widths, and unpacker state encoding, in shared package decoder_pkg.
REQ-029 SHALL instantiate one sub-module stream_fifo_mem (synchronous DEPTH x (LANES*DATA_WIDTH+LANES+2) storage, pointers, LEVEL).

Verification (DATA_WIDTH=16, LANES=5, DEPTH=8)
REQ-030 SHALL test one beat 0x0005_0004_0003_0002_0001, KEEP=5'b11111, TUSER=1, TLAST=1, M_TREADY=1 -> samples 1,2,3,4,5 consecutive cycles, TUSER on 1, TLAST on 5, first at cycle 2.
REQ-031 SHALL test last beat KEEP=5'b00111 -> three samples, M_TLAST on third, KEEP_ERR=0.
REQ-032 SHALL test M_TREADY=0, 9 beats offered -> 8 accepted plus 1 in unpacker at most, S_TREADY=0 at LEVEL=8, ALMOST_FULL=1 at LEVEL>=4.
REQ-033 SHALL test random M_TREADY over 1920 beats -> output sequence equals input lanes in order, no loss/duplication.
REQ-034 SHALL test KEEP=5'b00000 beat -> no output, KEEP_ERR=1 sticky.
REQ-035 SHALL test ARESET_N pulse mid-frame -> all outputs zero asynchronously, following frame emitted correctly from TUSER.
